cpu_run_ctrl: RTL and testbench

Run sequencer for the 5-stage pipelined CPU. It writes a program into instruction memory and an initial image into data memory through the CPU's external memory ports, taking both from one valid/ready load stream. It then drives the CPU `enable` until a halt PC is reached or a cycle budget expires, and drains the pipeline. In the DONE state it serves data-memory readback requests. It sits between the testbench or host and the `cpu` top-level ports.

---
 rtl/cpu_ctrl_pkg.sv | 20 ++
 rtl/readback_port.sv | 37 +++
 rtl/cpu_run_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the CPU run sequencer
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_I,
    ST_LOAD_D,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } run_state_e;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int WORD_BYTES       = 4;

  function automatic logic [31:0] word_to_byte(input logic [31:0] idx);
    return idx * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/readback_port.sv
// rtl/readback_port.sv - single-outstanding data-memory readback pipeline for the DONE state
module readback_port (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_enable,
  input  logic        i_req,
  input  logic [31:0] i_rdata,
  output logic        o_issue,
  output logic        o_valid,
  output logic [31:0] o_data
);

  logic        r_pending;
  logic        r_valid;
  logic [31:0] r_data;

  // The memory read is combinational while the read enable is up, so data is captured in the pending cycle.
  assign o_issue = i_enable && i_req && !r_pending;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_pending <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      r_pending <= o_issue;
      r_valid   <= r_pending;
      if (r_pending) begin
        r_data <= i_rdata;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - load, run, drain and readback sequencer for the pipelined CPU
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W        = 11,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_n_instr,
  input  logic [CNT_W-1:0] i_n_data,
  input  logic [31:0]      i_halt_pc,
  input  logic [31:0]      i_max_cycles,
  input  logic             i_ld_valid,
  output logic             o_ld_ready,
  input  logic [31:0]      i_ld_data,
  input  logic [31:0]      i_cpu_pc,
  output logic             o_cpu_enable,
  output logic [31:0]      o_imem_addr_ext,
  output logic [31:0]      o_imem_wdata_ext,
  output logic             o_imem_wen_ext,
  output logic [31:0]      o_dmem_addr_ext,
  output logic [31:0]      o_dmem_wdata_ext,
  output logic             o_dmem_wen_ext,
  output logic             o_dmem_ren_ext,
  input  logic [31:0]      i_dmem_rdata_ext,
  input  logic             i_rd_req,
  input  logic [CNT_W-1:0] i_rd_addr,
  output logic             o_rd_valid,
  output logic [31:0]      o_rd_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [31:0]      o_cycle_count
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  run_state_e       r_state;
  logic [CNT_W-1:0] r_n_instr;
  logic [CNT_W-1:0] r_n_data;
  logic [CNT_W-1:0] r_k;
  logic [31:0]      r_halt_pc;
  logic [31:0]      r_max;
  logic [31:0]      r_pc;
  logic [31:0]      r_cnt;
  logic [DRN_W-1:0] r_drain;
  logic             r_ld_ready;
  logic             r_cpu_en;
  logic             r_imem_wen;
  logic [31:0]      r_imem_addr;
  logic [31:0]      r_imem_wdata;
  logic             r_dmem_wen;
  logic             r_dmem_ren;
  logic [31:0]      r_dmem_addr;
  logic [31:0]      r_dmem_wdata;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;

  logic w_hs;
  logic w_last_i;
  logic w_last_d;
  logic w_rb_en;
  logic w_rb_issue;

  assign w_hs     = i_ld_valid && r_ld_ready;
  assign w_last_i = (r_k == r_n_instr - CNT_W'(1));
  assign w_last_d = (r_k == r_n_data - CNT_W'(1));
  assign w_rb_en  = (r_state == ST_DONE);

  readback_port u_readback (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_enable (w_rb_en),
    .i_req    (i_rd_req),
    .i_rdata  (i_dmem_rdata_ext),
    .o_issue  (w_rb_issue),
    .o_valid  (o_rd_valid),
    .o_data   (o_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state      <= ST_IDLE;
      r_n_instr    <= '0;
      r_n_data     <= '0;
      r_k          <= '0;
      r_halt_pc    <= '0;
      r_max        <= '0;
      r_pc         <= '0;
      r_cnt        <= '0;
      r_drain      <= '0;
      r_ld_ready   <= 1'b0;
      r_cpu_en     <= 1'b0;
      r_imem_wen   <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_wen   <= 1'b0;
      r_dmem_ren   <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_pc       <= i_cpu_pc;
      r_imem_wen <= 1'b0;
      r_dmem_wen <= 1'b0;
      r_dmem_ren <= w_rb_issue;
      if (w_rb_issue) begin
        r_dmem_addr <= word_to_byte(32'(i_rd_addr));
      end
      if (r_cpu_en && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 32'd1;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_n_instr <= i_n_instr;
            r_n_data  <= i_n_data;
            r_halt_pc <= i_halt_pc;
            r_max     <= i_max_cycles;
            r_k       <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b1;
            if (i_n_instr != '0) begin
              r_state    <= ST_LOAD_I;
              r_ld_ready <= 1'b1;
            end else if (i_n_data != '0) begin
              r_state    <= ST_LOAD_D;
              r_ld_ready <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end

        ST_LOAD_I: begin
          if (w_hs) begin
            r_imem_wen   <= 1'b1;
            r_imem_addr  <= word_to_byte(32'(r_k));
            r_imem_wdata <= i_ld_data;
            if (w_last_i) begin
              r_k <= '0;
              if (r_n_data != '0) begin
                r_state <= ST_LOAD_D;
              end else begin
                r_state    <= ST_RUN;
                r_ld_ready <= 1'b0;
              end
            end else begin
              r_k <= r_k + CNT_W'(1);
            end
          end
        end

        ST_LOAD_D: begin
          if (w_hs) begin
            r_dmem_wen   <= 1'b1;
            r_dmem_addr  <= word_to_byte(32'(r_k));
            r_dmem_wdata <= i_ld_data;
            if (w_last_d) begin
              r_k        <= '0;
              r_state    <= ST_RUN;
              r_ld_ready <= 1'b0;
            end else begin
              r_k <= r_k + CNT_W'(1);
            end
          end
        end

        // The first RUN cycle only raises enable, so the last load write lands before the CPU moves.
        ST_RUN: begin
          if (!r_cpu_en) begin
            r_cpu_en <= 1'b1;
          end else if (r_pc == r_halt_pc) begin
            r_state <= ST_DRAIN;
            r_drain <= '0;
          end else if ((r_max != 32'd0) && (r_cnt + 32'd1 == r_max)) begin
            r_state   <= ST_DONE;
            r_cpu_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (r_drain == DRN_W'(DRAIN_CYCLES - 1)) begin
            r_state  <= ST_DONE;
            r_cpu_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_drain <= r_drain + DRN_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ld_ready       = r_ld_ready;
  assign o_cpu_enable     = r_cpu_en;
  assign o_imem_addr_ext  = r_imem_addr;
  assign o_imem_wdata_ext = r_imem_wdata;
  assign o_imem_wen_ext   = r_imem_wen;
  assign o_dmem_addr_ext  = r_dmem_addr;
  assign o_dmem_wdata_ext = r_dmem_wdata;
  assign o_dmem_wen_ext   = r_dmem_wen;
  assign o_dmem_ren_ext   = r_dmem_ren;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_timeout        = r_timeout;
  assign o_cycle_count    = r_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             start;
  logic [CNT_W-1:0] n_instr, n_data;
  logic [31:0]      halt_pc, max_cycles;
  logic             ld_valid, ld_ready;
  logic [31:0]      ld_data;
  logic [31:0]      cpu_pc;
  logic             cpu_enable;
  logic [31:0]      imem_addr, imem_wdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic             imem_wen, dmem_wen, dmem_ren;
  logic             rd_req, rd_valid;
  logic [CNT_W-1:0] rd_addr;
  logic [31:0]      rd_data;
  logic             busy, done, timeout;
  logic [31:0]      cycle_count;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          en_cycles = 0;
  int          en_rise = -1;
  int          en_fall = -1;
  logic        en_prev = 1'b0;
  int          start_cyc;
  int          b_iw, b_dw, b_en;
  int          hs_cyc[$];
  int          iw_cyc[$], dw_cyc[$];
  logic [31:0] iw_addr[$], iw_data[$], dw_addr[$], dw_data[$];
  logic [31:0] ld_words [16];
  logic [31:0] dmem_mem [64];

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(4)) dut (
    .i_clk            (clk),
    .i_arst_n         (arst_n),
    .i_start          (start),
    .i_n_instr        (n_instr),
    .i_n_data         (n_data),
    .i_halt_pc        (halt_pc),
    .i_max_cycles     (max_cycles),
    .i_ld_valid       (ld_valid),
    .o_ld_ready       (ld_ready),
    .i_ld_data        (ld_data),
    .i_cpu_pc         (cpu_pc),
    .o_cpu_enable     (cpu_enable),
    .o_imem_addr_ext  (imem_addr),
    .o_imem_wdata_ext (imem_wdata),
    .o_imem_wen_ext   (imem_wen),
    .o_dmem_addr_ext  (dmem_addr),
    .o_dmem_wdata_ext (dmem_wdata),
    .o_dmem_wen_ext   (dmem_wen),
    .o_dmem_ren_ext   (dmem_ren),
    .i_dmem_rdata_ext (dmem_rdata),
    .i_rd_req         (rd_req),
    .i_rd_addr        (rd_addr),
    .o_rd_valid       (rd_valid),
    .o_rd_data        (rd_data),
    .o_busy           (busy),
    .o_done           (done),
    .o_timeout        (timeout),
    .o_cycle_count    (cycle_count)
  );

  assign dmem_rdata = dmem_ren ? dmem_mem[dmem_addr[7:2]] : 32'h0;

  // CPU stand-in: PC advances one word per enabled cycle, cleared by the shared reset.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) cpu_pc <= 32'h0;
    else if (cpu_enable) cpu_pc <= cpu_pc + 32'd4;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_wen) begin
      iw_cyc.push_back(cyc); iw_addr.push_back(imem_addr); iw_data.push_back(imem_wdata);
    end
    if (dmem_wen) begin
      dw_cyc.push_back(cyc); dw_addr.push_back(dmem_addr); dw_data.push_back(dmem_wdata);
      dmem_mem[dmem_addr[7:2]] = dmem_wdata;
    end
    if (cpu_enable) en_cycles++;
    if (cpu_enable && !en_prev) en_rise = cyc;
    if (!cpu_enable && en_prev) en_fall = cyc;
    en_prev = cpu_enable;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_flags"}, {ld_ready, cpu_enable, imem_wen, dmem_wen, dmem_ren,
                               rd_valid, busy, done, timeout}, 32'h0);
    check_eq({tag, "_imem"}, imem_addr | imem_wdata, 32'h0);
    check_eq({tag, "_dmem"}, dmem_addr | dmem_wdata, 32'h0);
    check_eq({tag, "_rd_data"}, rd_data, 32'h0);
    check_eq({tag, "_cycle_count"}, cycle_count, 32'h0);
  endtask

  task automatic run_start(input int ni, input int nd, input logic [31:0] hp, input logic [31:0] mc);
    @(negedge clk);
    b_iw = iw_addr.size(); b_dw = dw_addr.size(); b_en = en_cycles;
    hs_cyc.delete();
    n_instr = CNT_W'(ni); n_data = CNT_W'(nd); halt_pc = hp; max_cycles = mc;
    start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_stream(input string tag, input int n, input bit stall);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (idx < n && guard < 400) begin
      @(negedge clk);
      guard++;
      ld_valid = stall ? ph : 1'b1;
      ph = ~ph;
      ld_data = ld_words[idx];
      if (ld_valid && ld_ready) begin
        hs_cyc.push_back(cyc);
        idx++;
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    check_eq({tag, "_stream_done"}, idx, n);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done_seen"}, done, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_load(input string tag, input int ni, input int nd);
    int last_hs;
    check_eq({tag, "_iw_cnt"}, iw_addr.size() - b_iw, ni);
    check_eq({tag, "_dw_cnt"}, dw_addr.size() - b_dw, nd);
    for (int k = 0; k < ni && b_iw + k < iw_addr.size(); k++) begin
      check_eq($sformatf("%s_iw_addr%0d", tag, k), iw_addr[b_iw+k], 32'(4 * k));
      check_eq($sformatf("%s_iw_data%0d", tag, k), iw_data[b_iw+k], ld_words[k]);
      check_eq($sformatf("%s_iw_lat%0d", tag, k), iw_cyc[b_iw+k],
               (k < hs_cyc.size()) ? hs_cyc[k] + 1 : -1);
    end
    for (int k = 0; k < nd && b_dw + k < dw_addr.size(); k++) begin
      check_eq($sformatf("%s_dw_addr%0d", tag, k), dw_addr[b_dw+k], 32'(4 * k));
      check_eq($sformatf("%s_dw_data%0d", tag, k), dw_data[b_dw+k], ld_words[ni+k]);
      check_eq($sformatf("%s_dw_lat%0d", tag, k), dw_cyc[b_dw+k],
               (ni + k < hs_cyc.size()) ? hs_cyc[ni+k] + 1 : -1);
    end
    last_hs = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -100;
    check_eq({tag, "_en_rise"}, en_rise, last_hs + 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    arst_n = 1'b0; start = 1'b0; n_instr = '0; n_data = '0; halt_pc = '0; max_cycles = '0;
    ld_valid = 1'b0; ld_data = '0; rd_req = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    arst_n = 1'b1;

    // 3 instr + 2 data, no stalls, halt at PC 0x10: 6 run cycles + 4 drain.
    for (int k = 0; k < 5; k++) ld_words[k] = 32'hA000_0000 + 32'(k * 17);
    run_start(3, 2, 32'h10, 32'd100);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_ld_ready", ld_ready, 1'b1);
    load_stream("t1", 5, 1'b0);
    wait_done("t1");
    check_load("t1", 3, 2);
    check_eq("t1_hs_span", (hs_cyc.size() == 5) ? hs_cyc[4] - hs_cyc[0] : -1, 4);
    check_eq("t1_timeout", timeout, 1'b0);
    check_eq("t1_cycle_count", cycle_count, 32'd10);
    check_eq("t1_en_cycles", en_cycles - b_en, 10);
    check_eq("t1_en_span", en_fall - en_rise, 10);
    check_eq("t1_status", {busy, cpu_enable, ld_ready}, 3'b000);

    // Stalled stream, 2 instr + 4 data, unreachable halt, budget 20.
    for (int k = 0; k < 6; k++) ld_words[k] = 32'h5500_0000 + 32'(k * 257);
    run_start(2, 4, 32'hFFFF_FFF0, 32'd20);
    check_eq("t2_done_cleared", done, 1'b0);
    check_eq("t2_count_cleared", cycle_count, 32'd0);
    load_stream("t2", 6, 1'b1);
    wait_done("t2");
    check_load("t2", 2, 4);
    check_eq("t2_timeout", timeout, 1'b1);
    check_eq("t2_cycle_count", cycle_count, 32'd20);
    check_eq("t2_en_cycles", en_cycles - b_en, 20);
    check_eq("t2_cpu_enable", cpu_enable, 1'b0);

    // Readback of word 2; a second request while pending is dropped.
    @(negedge clk);
    rd_addr = CNT_W'(2); rd_req = 1'b1;
    @(negedge clk);
    check_eq("rb_ren", dmem_ren, 1'b1);
    check_eq("rb_addr", dmem_addr, 32'h8);
    check_eq("rb_valid_early", rd_valid, 1'b0);
    rd_addr = CNT_W'(3);
    @(negedge clk);
    check_eq("rb_valid", rd_valid, 1'b1);
    check_eq("rb_data", rd_data, ld_words[4]);
    check_eq("rb_second_ignored", dmem_ren, 1'b0);
    rd_req = 1'b0;
    @(negedge clk);
    check_eq("rb_valid_pulse", rd_valid, 1'b0);

    // Reset in the middle of LOAD_D aborts everything.
    for (int k = 0; k < 6; k++) ld_words[k] = 32'hC300_0000 + 32'(k + 1);
    run_start(1, 5, 32'h10, 32'd0);
    load_stream("t4", 3, 1'b0);
    arst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check_zero("rst_idle");

    // Empty load: RUN one cycle after start, unlimited budget, stray start/rd_req ignored.
    run_start(0, 0, 32'h10, 32'd0);
    s0 = start_cyc;
    check_eq("t5_busy", busy, 1'b1);
    check_eq("t5_no_ready", {ld_ready, cpu_enable}, 2'b00);
    @(negedge clk);
    check_eq("t5_enable", cpu_enable, 1'b1);
    rd_addr = CNT_W'(1); rd_req = 1'b1;
    run_start(0, 0, 32'h10, 32'd0);
    rd_req = 1'b0;
    check_eq("t5_rd_outside_done", dmem_ren, 1'b0);
    wait_done("t5");
    check_eq("t5_en_rise", en_rise, s0 + 2);
    check_eq("t5_cycle_count", cycle_count, 32'd10);
    check_eq("t5_timeout", timeout, 1'b0);
    check_eq("t5_no_writes", iw_addr.size() + dw_addr.size() - b_iw - b_dw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
